// File: rtl/stream_unpacker_pkg.sv
// Shared stream definitions for the wide<->narrow lane converters.
// Holds FSM encodings and default lane/word widths so the unpacker and a
// future packer agree on the same framing vocabulary.
package stream_unpacker_pkg;

  // Default widths: one byte lane, four lanes per word.
  localparam int unsigned SU_LANE_BITS  = 8;
  localparam int unsigned SU_WORD_BITS  = 32;
  localparam int unsigned SU_RATIO      = SU_WORD_BITS / SU_LANE_BITS;
  localparam int unsigned SU_RATIO_LOG2 = 2;

  // Converter state: IDLE holds no word, SHIFT is walking lanes of a held word.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } stream_state_e;

  // Lane-counter width for a given ratio, never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned ratio);
    int unsigned b;
    b = 1;
    while ((1 << b) < ratio) b++;
    return b;
  endfunction

endpackage

// File: rtl/stream_unpacker.sv
// Unpacks wide stream words into little-endian narrow lanes with packet framing.
// Latency: lane 0 appears one cycle after the word is accepted; full throughput.
// Backpressure: i_src_ready=0 freezes the lane outputs and holds off o_snk_ready.
module stream_unpacker
  import stream_unpacker_pkg::*;
#(
  parameter int unsigned p_st_bits    = SU_WORD_BITS,
  parameter int unsigned p_out_bits   = SU_LANE_BITS,
  parameter int unsigned p_ratio      = SU_RATIO,
  parameter int unsigned p_ratio_log2 = SU_RATIO_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [p_st_bits-1:0]    i_snk_data,
  input  logic                    i_snk_last,
  input  logic [p_ratio_log2-1:0] i_snk_nbytes,
  input  logic                    i_snk_valid,
  output logic                    o_snk_ready,
  output logic [p_out_bits-1:0]   o_src_data,
  output logic                    o_src_last,
  output logic                    o_src_valid,
  input  logic                    i_src_ready,
  output logic                    o_busy
);

  // Highest lane index of a full word.
  localparam logic [p_ratio_log2-1:0] LimitFull = p_ratio_log2'(p_ratio - 1);

  stream_state_e           state_q, state_d;
  logic [p_ratio_log2-1:0] cnt_q, cnt_d;
  logic [p_ratio_log2-1:0] limit_q, limit_d;
  logic [p_st_bits-1:0]    word_q, word_d;
  logic                    lastflag_q, lastflag_d;
  logic                    rdy_en_q;

  logic                    shifting;
  logic                    at_limit;
  logic                    src_xfer;
  logic                    snk_acc;
  logic [p_ratio_log2-1:0] nb_clamped;
  logic [p_out_bits-1:0]   lane_mux;

  assign shifting = (state_q == ST_SHIFT);
  assign at_limit = (cnt_q == limit_q);
  assign src_xfer = shifting & i_src_ready;

  // Ready when empty, or when the final lane of the held word leaves this
  // cycle so the next word loads with no bubble.
  assign o_snk_ready = rdy_en_q & (~shifting | (src_xfer & at_limit));
  assign snk_acc     = i_snk_valid & o_snk_ready;

  // A lane count beyond the word is clamped to a full word, never wrapped.
  assign nb_clamped = (i_snk_nbytes > LimitFull) ? LimitFull : i_snk_nbytes;

  // Select the current lane; lane 0 is the least significant slice.
  always_comb begin
    lane_mux = '0;
    for (int i = 0; i < int'(p_ratio); i++) begin
      if (cnt_q == p_ratio_log2'(i)) begin
        lane_mux = word_q[i*p_out_bits +: p_out_bits];
      end
    end
  end

  assign o_src_valid = shifting;
  assign o_src_data  = lane_mux;
  assign o_src_last  = shifting & lastflag_q & at_limit;
  assign o_busy      = shifting;

  // Next-state: load on accept, advance on transfer, go idle after last lane.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    limit_d    = limit_q;
    word_d     = word_q;
    lastflag_d = lastflag_q;
    if (snk_acc) begin
      state_d    = ST_SHIFT;
      cnt_d      = '0;
      word_d     = i_snk_data;
      limit_d    = i_snk_last ? nb_clamped : LimitFull;
      lastflag_d = i_snk_last;
    end else if (src_xfer) begin
      if (at_limit) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset discards any held word, ready enables one edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      limit_q    <= '0;
      word_q     <= '0;
      lastflag_q <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      word_q     <= word_d;
      lastflag_q <= lastflag_d;
      rdy_en_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker: per-cycle vector table plus reset sequences.
// Inputs change on the falling edge; outputs are compared before the next rising edge.
// All expected values are hand-computed constants.
module tb_stream_unpacker;

  logic        clk;
  logic        rst;
  logic [31:0] i_snk_data;
  logic        i_snk_last;
  logic [1:0]  i_snk_nbytes;
  logic        i_snk_valid;
  logic        o_snk_ready;
  logic [7:0]  o_src_data;
  logic        o_src_last;
  logic        o_src_valid;
  logic        i_src_ready;
  logic        o_busy;

  int errors = 0;
  int checks = 0;

  stream_unpacker #(
    .p_st_bits   (32),
    .p_out_bits  (8),
    .p_ratio     (4),
    .p_ratio_log2(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_snk_data  (i_snk_data),
    .i_snk_last  (i_snk_last),
    .i_snk_nbytes(i_snk_nbytes),
    .i_snk_valid (i_snk_valid),
    .o_snk_ready (o_snk_ready),
    .o_src_data  (o_src_data),
    .o_src_last  (o_src_last),
    .o_src_valid (o_src_valid),
    .i_src_ready (i_src_ready),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] d;
    logic        last;
    logic [1:0]  nb;
    logic        rdy;
    logic        e_sv;
    logic [7:0]  e_sd;
    logic        e_sl;
    logic        e_sr;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic v, input logic [31:0] d,
                     input logic last, input logic [1:0] nb, input logic rdy,
                     input logic e_sv, input logic [7:0] e_sd, input logic e_sl,
                     input logic e_sr, input logic e_busy);
    vec_t r;
    r.name = name; r.v = v; r.d = d; r.last = last; r.nb = nb; r.rdy = rdy;
    r.e_sv = e_sv; r.e_sd = e_sd; r.e_sl = e_sl; r.e_sr = e_sr; r.e_busy = e_busy;
    vq.push_back(r);
  endtask

  // Compare all outputs; data is only compared where chk_d is set.
  task automatic chk(input string name, input logic e_sv, input logic [7:0] e_sd,
                     input logic chk_d, input logic e_sl, input logic e_sr,
                     input logic e_busy);
    checks++;
    if (o_src_valid !== e_sv || (chk_d && o_src_data !== e_sd) ||
        o_src_last !== e_sl || o_snk_ready !== e_sr || o_busy !== e_busy) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h last=%b snk_ready=%b busy=%b, want valid=%b data=%h%s last=%b snk_ready=%b busy=%b",
               name, o_src_valid, o_src_data, o_src_last, o_snk_ready, o_busy,
               e_sv, e_sd, chk_d ? "" : "(any)", e_sl, e_sr, e_busy);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic last,
                       input logic [1:0] nb, input logic rdy);
    i_snk_valid  = v;
    i_snk_data   = d;
    i_snk_last   = last;
    i_snk_nbytes = nb;
    i_src_ready  = rdy;
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Single full word; nbytes ignored because last=0.
    add("w1_accept", 1, 32'h44332211, 0, 2'd1, 1,  0, 8'h00, 0, 1, 0);
    add("w1_l0",     0, 32'h0,        0, 2'd0, 1,  1, 8'h11, 0, 0, 1);
    add("w1_l1",     0, 32'h0,        0, 2'd0, 1,  1, 8'h22, 0, 0, 1);
    add("w1_l2",     0, 32'h0,        0, 2'd0, 1,  1, 8'h33, 0, 0, 1);
    add("w1_l3",     0, 32'h0,        0, 2'd0, 1,  1, 8'h44, 0, 1, 1);
    add("w1_idle",   0, 32'h0,        0, 2'd0, 1,  0, 8'h00, 0, 1, 0);
    // Back-to-back words, no bubble.
    add("b2b_acc",   1, 32'h04030201, 0, 2'd0, 1,  0, 8'h00, 0, 1, 0);
    add("b2b_01",    1, 32'h08070605, 0, 2'd0, 1,  1, 8'h01, 0, 0, 1);
    add("b2b_02",    1, 32'h08070605, 0, 2'd0, 1,  1, 8'h02, 0, 0, 1);
    add("b2b_03",    1, 32'h08070605, 0, 2'd0, 1,  1, 8'h03, 0, 0, 1);
    add("b2b_04",    1, 32'h08070605, 0, 2'd0, 1,  1, 8'h04, 0, 1, 1);
    add("b2b_05",    0, 32'h0,        0, 2'd0, 1,  1, 8'h05, 0, 0, 1);
    add("b2b_06",    0, 32'h0,        0, 2'd0, 1,  1, 8'h06, 0, 0, 1);
    add("b2b_07",    0, 32'h0,        0, 2'd0, 1,  1, 8'h07, 0, 0, 1);
    add("b2b_08",    0, 32'h0,        0, 2'd0, 1,  1, 8'h08, 0, 1, 1);
    add("b2b_idle",  0, 32'h0,        0, 2'd0, 1,  0, 8'h00, 0, 1, 0);
    // Short last word: two lanes.
    add("sh_acc",    1, 32'hDDCCBBAA, 1, 2'd1, 1,  0, 8'h00, 0, 1, 0);
    add("sh_aa",     0, 32'h0,        0, 2'd0, 1,  1, 8'hAA, 0, 0, 1);
    add("sh_bb",     0, 32'h0,        0, 2'd0, 1,  1, 8'hBB, 1, 1, 1);
    add("sh_idle",   0, 32'h0,        0, 2'd0, 1,  0, 8'h00, 0, 1, 0);
    // Single-lane last word.
    add("one_acc",   1, 32'h000000EE, 1, 2'd0, 1,  0, 8'h00, 0, 1, 0);
    add("one_ee",    0, 32'h0,        0, 2'd0, 1,  1, 8'hEE, 1, 1, 1);
    add("one_idle",  0, 32'h0,        0, 2'd0, 1,  0, 8'h00, 0, 1, 0);
    // Alternating backpressure; next word waits while last lane stalls.
    add("bp_acc",    1, 32'h44332211, 0, 2'd0, 1,  0, 8'h00, 0, 1, 0);
    add("bp_11s",    0, 32'h0,        0, 2'd0, 0,  1, 8'h11, 0, 0, 1);
    add("bp_11",     0, 32'h0,        0, 2'd0, 1,  1, 8'h11, 0, 0, 1);
    add("bp_22s",    0, 32'h0,        0, 2'd0, 0,  1, 8'h22, 0, 0, 1);
    add("bp_22",     0, 32'h0,        0, 2'd0, 1,  1, 8'h22, 0, 0, 1);
    add("bp_33s",    0, 32'h0,        0, 2'd0, 0,  1, 8'h33, 0, 0, 1);
    add("bp_33",     0, 32'h0,        0, 2'd0, 1,  1, 8'h33, 0, 0, 1);
    add("bp_44s",    1, 32'h0C0B0A09, 1, 2'd3, 0,  1, 8'h44, 0, 0, 1);
    add("bp_44",     1, 32'h0C0B0A09, 1, 2'd3, 1,  1, 8'h44, 0, 1, 1);
    // Last word with nbytes=3: all four lanes, last flag on lane 3.
    add("f_09",      0, 32'h0,        0, 2'd0, 1,  1, 8'h09, 0, 0, 1);
    add("f_0a",      0, 32'h0,        0, 2'd0, 1,  1, 8'h0A, 0, 0, 1);
    add("f_0b",      0, 32'h0,        0, 2'd0, 1,  1, 8'h0B, 0, 0, 1);
    add("f_0c",      0, 32'h0,        0, 2'd0, 1,  1, 8'h0C, 1, 1, 1);
    add("f_idle",    0, 32'h0,        0, 2'd0, 1,  0, 8'h00, 0, 1, 0);

    // ---------------- reset with valid asserted ----------------
    rst = 1'b0;
    drive(1, 32'hDEADBEEF, 0, 2'd0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2 chk($sformatf("rst_hold%0d", i), 0, 8'h00, 1, 0, 0, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    #2 chk("rst_release", 0, 8'h00, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 32'h0, 0, 2'd0, 1);
    #2 chk("rst_ready_up", 0, 8'h00, 0, 0, 1, 0);

    // ---------------- table ----------------
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].v, vq[i].d, vq[i].last, vq[i].nb, vq[i].rdy);
      #2 chk(vq[i].name, vq[i].e_sv, vq[i].e_sd, vq[i].e_sv, vq[i].e_sl,
             vq[i].e_sr, vq[i].e_busy);
    end

    // ---------------- reset mid-word ----------------
    @(negedge clk);
    drive(1, 32'h44332211, 0, 2'd0, 1);
    #2 chk("mr_acc", 0, 8'h00, 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 32'h0, 0, 2'd0, 1);
    #2 chk("mr_11", 1, 8'h11, 1, 0, 0, 1);
    @(negedge clk);
    #2 chk("mr_22", 1, 8'h22, 1, 0, 0, 1);
    @(negedge clk);
    #1 chk("mr_33", 1, 8'h33, 1, 0, 0, 1);
    #1 rst = 1'b0;
    drive(1, 32'h12345678, 0, 2'd0, 1);
    #1 chk("mr_async_drop", 0, 8'h00, 1, 0, 0, 0);
    @(negedge clk);
    #2 chk("mr_in_reset", 0, 8'h00, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 32'h0, 0, 2'd0, 1);
    #2 chk("mr_release", 0, 8'h00, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'h0000BEEF, 0, 2'd0, 1);
    #2 chk("mr_ready", 0, 8'h00, 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 32'h0, 0, 2'd0, 1);
    #2 chk("mr_ef", 1, 8'hEF, 1, 0, 0, 1);
    @(negedge clk);
    #2 chk("mr_be", 1, 8'hBE, 1, 0, 0, 1);
    @(negedge clk);
    #2 chk("mr_00a", 1, 8'h00, 1, 0, 0, 1);
    @(negedge clk);
    #2 chk("mr_00b", 1, 8'h00, 1, 0, 1, 1);
    @(negedge clk);
    #2 chk("mr_idle", 0, 8'h00, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_unpacker.md
Name: stream_unpacker

Overview:
- Reader-side companion to the team's stream FIFO (mFifo).
- Drains wide words from the FIFO source port over a valid/ready handshake and re-emits each word as a sequence of narrow lanes on its own valid/ready source port.
- Handles packet framing: a last word may carry fewer valid lanes, and the final lane is flagged.
- Sits between mFifo and narrow-datapath consumers (byte transmitters, serial links).

Parameters:
- p_st_bits, 32: width of the input word; must equal p_out_bits * p_ratio.
- p_out_bits, 8: width of one output lane.
- p_ratio, 4: lanes per word.
- p_ratio_log2, 2: width of lane counter and i_snk_nbytes; ceil(log2(p_ratio)), minimum 1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_snk_data  in  p_st_bits  input word; lane 0 = bits [p_out_bits-1:0].
- i_snk_last  in  1  word is the final word of a packet.
- i_snk_nbytes  in  p_ratio_log2  valid lanes minus 1; used only when i_snk_last=1.
- i_snk_valid  in  1  input word present.
- o_snk_ready  out  1  block accepts the word this cycle.
- o_src_data  out  p_out_bits  current lane.
- o_src_last  out  1  current lane is the final lane of a packet.
- o_src_valid  out  1  lane present.
- i_src_ready  in  1  downstream accepts the lane this cycle.
- o_busy  out  1  a word is held (state SHIFT).

Behaviour:
- Reset asserted (rst=0), asynchronous:
  - state=IDLE, lane counter=0, word register=0, last/limit registers=0, ready-enable flop=0.
  - All outputs 0, including o_snk_ready.
  - o_src_valid drops immediately, without waiting for a clock edge.
- After release: ready-enable flop sets on the first rising edge; o_snk_ready may rise only after that edge.
- States:
  - IDLE: no word held.
  - SHIFT: word held; emitting lanes.
- Handshakes:
  - Input accept = i_snk_valid & o_snk_ready.
  - Output transfer = o_src_valid & i_src_ready.
- o_snk_ready (combinational from registers and i_src_ready) =
  - ready-enable & (state==IDLE | (state==SHIFT & transfer & cnt==limit)).
  - This gives full throughput: a new word loads in the same cycle the final lane of the previous word transfers.
- On accept:
  - word <= i_snk_data; cnt <= 0.
  - limit <= i_snk_last ? i_snk_nbytes : p_ratio-1.
  - lastflag <= i_snk_last; state <= SHIFT.
- Latency: word accepted on edge N -> lane 0 on o_src_valid after edge N, one cycle later.
- In SHIFT:
  - o_src_valid=1; o_src_data = word[cnt*p_out_bits +: p_out_bits].
  - o_src_last = lastflag & (cnt==limit).
- Transfer with cnt<limit: cnt <= cnt+1.
- Transfer with cnt==limit:
  - With new accept in the same cycle: reload as above.
  - Without: state <= IDLE, cnt <= 0.
- Backpressure (i_src_ready=0): o_src_data, o_src_last and o_src_valid hold stable; cnt unchanged; o_snk_ready=0.
- i_snk_nbytes ≥ p_ratio-1 with last=1: all lanes emitted; the value is never wrapped or truncated below the lane count.
- i_snk_nbytes is ignored when i_snk_last=0.
- Lanes above limit are never emitted and never stall the block.
- Lane order is fixed little-endian: lane 0 first.
- o_busy = (state==SHIFT).
- Reset mid-word: the held word is discarded. After release, the next accepted word starts at lane 0. No partial lane is re-emitted.
- i_snk_valid while in reset is ignored. Upstream data is not consumed.

Decomposition:
- Shared stream package/include holds:
  - state encodings (IDLE=0, SHIFT=1);
  - default lane width constant (8) and word width constant (32), alongside the existing word/instruction widths in define.v.
- No sub-module needed. Lane mux and counter stay inline.
- A future packer (narrow -> wide) reuses the same package.

Test Plan:
1. Reset: hold rst=0 for 4 cycles with i_snk_valid=1 -> o_snk_ready=0, o_src_valid=0, o_busy=0 throughout; o_snk_ready=1 only after the first edge following release.
2. Single word: 0x44332211, last=0, i_src_ready=1 -> o_src_data 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting one cycle after accept; o_src_last=0; o_snk_ready=1 on the cycle 0x44 transfers.
3. Back-to-back: words 0x04030201 and 0x08070605 continuously valid, i_src_ready=1 -> bytes 0x01..0x08 on 8 consecutive cycles with no bubble.
4. Short last word: 0xDDCCBBAA, last=1, nbytes=1 -> 0xAA then 0xBB with o_src_last=1 on 0xBB; 0xCC and 0xDD never appear; block returns to IDLE.
5. Backpressure: word 0x44332211 with i_src_ready pattern 0,1,0,1,0,1,0,1 -> each byte held stable while ready=0; order 0x11..0x44 intact; completes in 8 cycles.
6. Reset mid-word: assert rst=0 after 0x11 and 0x22 transfer -> o_src_valid falls without a clock edge; after release, word 0x0000BEEF yields 0xEF first.
